// File: rtl/lane_note_controller.sv
// lane_note_controller
//
// Frame-synchronous gameplay controller for the lane display. Notes are
// spawned from an external asynchronous pattern ROM, scrolled down SPEED rows
// on every frame update and judged against the player's lane buttons inside
// the hit window [HIT_TOP, HIT_BOTTOM]. A note whose row passes MISS_ROW is
// retired as a miss.
//
// Optional feature (compile-time macro): MISS_PENALTY_EN
//   defined   : a button rising edge on a lane with no note inside the hit
//               window counts as a miss (note state is left alone)
//   undefined : such presses are ignored
//
// Ports
//   clk           in   pixel clock
//   rst_n         in   asynchronous active-low reset
//   frame_start   in   one-cycle pulse per video frame
//   start         in   level, begins a song from IDLE or DONE
//   btn           in   [NUM_LANES] debounced lane buttons, active high
//   pattern_data  in   [NUM_LANES] spawn mask at pattern_addr (same cycle)
//   pattern_addr  out  [ADDR_W] current pattern step
//   note_active   out  [NUM_LANES] lane holds a note
//   note_row      out  [10*NUM_LANES] note top rows, lane i at [10i+9:10i]
//   lane_flash    out  [NUM_LANES] hit flash flags
//   score         out  [16] hit count, saturating
//   misses        out  [16] miss count, saturating
//   done          out  song complete
//
// state | meaning
// ------+----------------------------------------------------------------
// IDLE  | after reset, waiting for start
// PLAY  | song running: frame updates move notes and spawn from pattern ROM
// DRAIN | pattern exhausted, remaining notes scroll out or get hit
// DONE  | all notes gone, done=1, waiting for start to replay

module lane_note_controller #(
    parameter int NUM_LANES    = 4,
    parameter int SPEED        = 4,
    parameter int HIT_TOP      = 400,
    parameter int HIT_BOTTOM   = 440,
    parameter int MISS_ROW     = 460,
    parameter int STEP_FRAMES  = 8,
    parameter int PATTERN_LEN  = 64,
    parameter int ADDR_W       = 8,
    parameter int FLASH_FRAMES = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    start,
    input  logic [NUM_LANES-1:0]    btn,
    input  logic [NUM_LANES-1:0]    pattern_data,
    output logic [ADDR_W-1:0]       pattern_addr,
    output logic [NUM_LANES-1:0]    note_active,
    output logic [10*NUM_LANES-1:0] note_row,
    output logic [NUM_LANES-1:0]    lane_flash,
    output logic [15:0]             score,
    output logic [15:0]             misses,
    output logic                    done
);

    localparam int SW = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;
    localparam int FW = $clog2(FLASH_FRAMES + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                           state_q, state_d;
    logic [ADDR_W-1:0]                addr_q, addr_d;
    logic [SW-1:0]                    step_q, step_d;
    logic [NUM_LANES-1:0]             active_q, active_d;
    logic [NUM_LANES-1:0][10:0]       row_q, row_d;
    logic [NUM_LANES-1:0]             flash_q, flash_d;
    logic [NUM_LANES-1:0][FW-1:0]     fcnt_q, fcnt_d;
    logic [15:0]                      score_q, score_d;
    logic [15:0]                      misses_q, misses_d;
    logic                             done_q, done_d;
    logic [NUM_LANES-1:0]             btn_prev_q;

    logic [NUM_LANES-1:0]             btn_rise;
    logic [7:0]                       hit_cnt;
    logic [7:0]                       miss_cnt;
    logic [10:0]                      moved;
    logic [16:0]                      score_sum;
    logic [16:0]                      miss_sum;

    assign btn_rise = btn & ~btn_prev_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        step_d    = step_q;
        active_d  = active_q;
        row_d     = row_q;
        flash_d   = flash_q;
        fcnt_d    = fcnt_q;
        hit_cnt   = '0;
        miss_cnt  = '0;
        moved     = '0;
        score_sum = {1'b0, score_q};
        miss_sum  = {1'b0, misses_q};
        score_d   = score_q;
        misses_d  = misses_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = PLAY;
                    addr_d   = '0;
                    step_d   = '0;
                    active_d = '0;
                    row_d    = '0;
                    flash_d  = '0;
                    fcnt_d   = '0;
                    score_d  = '0;
                    misses_d = '0;
                end
            end

            PLAY, DRAIN: begin
                for (int i = 0; i < NUM_LANES; i++) begin
                    // A hit is judged on the pre-update row and takes priority
                    // over the frame move, so a hit note never moves or misses.
                    if (btn_rise[i] && active_q[i] &&
                        row_q[i] >= 11'(HIT_TOP) && row_q[i] <= 11'(HIT_BOTTOM)) begin
                        active_d[i] = 1'b0;
                        flash_d[i]  = 1'b1;
                        fcnt_d[i]   = FW'(FLASH_FRAMES);
                        hit_cnt     = hit_cnt + 8'd1;
                    end else begin
`ifdef MISS_PENALTY_EN
                        if (btn_rise[i]) begin
                            miss_cnt = miss_cnt + 8'd1;
                        end
`endif
                        if (frame_start) begin
                            if (active_q[i]) begin
                                moved = row_q[i] + 11'(SPEED);
                                if (moved > 11'(MISS_ROW)) begin
                                    active_d[i] = 1'b0;
                                    miss_cnt    = miss_cnt + 8'd1;
                                end else begin
                                    row_d[i] = moved;
                                end
                            end
                            if (flash_q[i]) begin
                                fcnt_d[i] = fcnt_q[i] - FW'(1);
                                if (fcnt_q[i] <= FW'(1)) begin
                                    flash_d[i] = 1'b0;
                                end
                            end
                        end
                    end
                end

                if (frame_start) begin
                    if (state_q == PLAY) begin
                        if (step_q == '0) begin
                            // Spawn only into lanes still empty after the move;
                            // a spawn onto an occupied lane is dropped.
                            for (int i = 0; i < NUM_LANES; i++) begin
                                if (pattern_data[i] && !active_d[i]) begin
                                    active_d[i] = 1'b1;
                                    row_d[i]    = '0;
                                end
                            end
                            addr_d = addr_q + ADDR_W'(1);
                            if (addr_q == ADDR_W'(PATTERN_LEN - 1)) begin
                                state_d = DRAIN;
                            end
                        end
                        step_d = (step_q == SW'(STEP_FRAMES - 1)) ? '0 : step_q + SW'(1);
                    end else if (active_d == '0) begin
                        state_d = DONE;
                    end
                end

                score_sum = {1'b0, score_q} + {9'd0, hit_cnt};
                miss_sum  = {1'b0, misses_q} + {9'd0, miss_cnt};
                score_d   = score_sum[16] ? 16'hFFFF : score_sum[15:0];
                misses_d  = miss_sum[16] ? 16'hFFFF : miss_sum[15:0];
            end

            default: state_d = IDLE;
        endcase

        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            step_q     <= '0;
            active_q   <= '0;
            row_q      <= '0;
            flash_q    <= '0;
            fcnt_q     <= '0;
            score_q    <= '0;
            misses_q   <= '0;
            done_q     <= 1'b0;
            btn_prev_q <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            step_q     <= step_d;
            active_q   <= active_d;
            row_q      <= row_d;
            flash_q    <= flash_d;
            fcnt_q     <= fcnt_d;
            score_q    <= score_d;
            misses_q   <= misses_d;
            done_q     <= done_d;
            btn_prev_q <= btn;
        end
    end

    // Live notes never exceed MISS_ROW, so the low 10 bits carry the full row.
    always_comb begin
        note_row = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            note_row[10*i +: 10] = row_q[i][9:0];
        end
    end

    assign pattern_addr = addr_q;
    assign note_active  = active_q;
    assign lane_flash   = flash_q;
    assign score        = score_q;
    assign misses       = misses_q;
    assign done         = done_q;

endmodule

// File: tb/tb_lane_note_controller.sv
module tb_lane_note_controller;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_start = 1'b0;
    logic        start = 1'b0;
    logic [3:0]  btn = 4'b0;
    logic [3:0]  pattern_data;
    logic [7:0]  pattern_addr;
    logic [3:0]  note_active;
    logic [39:0] note_row;
    logic [3:0]  lane_flash;
    logic [15:0] score;
    logic [15:0] misses;
    logic        done;

    logic [3:0]  rom [0:63];

`ifdef MISS_PENALTY_EN
    localparam int PEN = 1;
`else
    localparam int PEN = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int fcount   = 0;

    always #5 clk = ~clk;

    assign pattern_data = (pattern_addr < 8'd64) ? rom[pattern_addr[5:0]] : 4'b0;

    lane_note_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .frame_start  (frame_start),
        .start        (start),
        .btn          (btn),
        .pattern_data (pattern_data),
        .pattern_addr (pattern_addr),
        .note_active  (note_active),
        .note_row     (note_row),
        .lane_flash   (lane_flash),
        .score        (score),
        .misses       (misses),
        .done         (done)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (frame %0d)", tag, obs, exp, fcount);
        end
    endtask

    function automatic int row_of(input int lane);
        return int'(note_row[10*lane +: 10]);
    endfunction

    task automatic frame();
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        fcount++;
        @(negedge clk);
    endtask

    task automatic run_to(input int n);
        while (fcount < n) frame();
    endtask

    task automatic press(input int lane);
        @(negedge clk) btn[lane] = 1'b1;
        @(negedge clk) btn[lane] = 1'b0;
        @(negedge clk);
    endtask

    task automatic frame_press(input int lane);
        @(negedge clk) begin
            frame_start = 1'b1;
            btn[lane]   = 1'b1;
        end
        @(negedge clk) begin
            frame_start = 1'b0;
            btn[lane]   = 1'b0;
        end
        fcount++;
        @(negedge clk);
    endtask

    task automatic pulse_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        for (int a = 0; a < 64; a++) rom[a] = 4'b0;
        rom[0]  = 4'b0001;
        rom[1]  = 4'b0011;
        rom[2]  = 4'b0100;
        rom[63] = 4'b1000;

        repeat (3) @(negedge clk);
        check("rst_addr",   pattern_addr, 0);
        check("rst_active", note_active, 0);
        check("rst_rows",   (note_row == 40'd0) ? 0 : 1, 0);
        check("rst_score",  score, 0);
        check("rst_misses", misses, 0);
        check("rst_done",   done, 0);
        check("rst_flash",  lane_flash, 0);
        rst_n = 1'b1;

        // frame pulse while idle does nothing
        @(negedge clk) frame_start = 1'b1;
        @(negedge clk) frame_start = 1'b0;
        @(negedge clk);
        check("idle_frame_addr",   pattern_addr, 0);
        check("idle_frame_active", note_active, 0);

        pulse_start();
        check("start_addr", pattern_addr, 0);
        check("start_done", done, 0);

        frame();
        check("spawn0_active", note_active, 4'b0001);
        check("spawn0_row",    row_of(0), 0);
        check("spawn0_addr",   pattern_addr, 1);
        frame();
        check("move_row",      row_of(0), 4);

        // start while playing is ignored
        pulse_start();
        check("start_play_addr", pattern_addr, 1);
        check("start_play_row",  row_of(0), 4);

        press(3);
        check("empty_press_misses", misses, PEN);
        press(0);
        check("early_press_active", note_active[0], 1);
        check("early_press_score",  score, 0);
        check("early_press_misses", misses, 2*PEN);

        run_to(9);
        check("occupied_active", note_active, 4'b0011);
        check("occupied_row0",   row_of(0), 32);
        check("occupied_row1",   row_of(1), 0);
        check("occupied_addr",   pattern_addr, 2);

        run_to(17);
        check("spawn2_active", note_active, 4'b0111);
        check("spawn2_row",    row_of(2), 0);

        run_to(106);
        check("pre_hit_row0", row_of(0), 420);
        press(0);
        check("hit_score",  score, 1);
        check("hit_active", note_active[0], 0);
        check("hit_flash",  lane_flash, 4'b0001);

        run_to(111);
        check("flash_5_frames", lane_flash[0], 1);
        run_to(112);
        check("flash_6_frames", lane_flash[0], 0);

        run_to(124);
        check("edge_row1",    row_of(1), 460);
        check("edge_active1", note_active[1], 1);
        run_to(125);
        check("miss_misses",  misses, 2*PEN + 1);
        check("miss_active1", note_active[1], 0);

        run_to(127);
        check("pre_sim_row2", row_of(2), 440);
        frame_press(2);
        check("sim_score",   score, 2);
        check("sim_misses",  misses, 2*PEN + 1);
        check("sim_active",  note_active, 0);
        check("sim_row_444", (row_of(2) == 444) ? 1 : 0, 0);

        run_to(504);
        check("addr_before_last", pattern_addr, 63);
        run_to(505);
        check("last_addr",   pattern_addr, 64);
        check("last_active", note_active, 4'b1000);
        check("last_row3",   row_of(3), 0);
        run_to(520);
        check("drain_addr",  pattern_addr, 64);
        check("drain_done",  done, 0);
        run_to(620);
        check("drain_row3",  row_of(3), 460);
        check("drain_done2", done, 0);
        run_to(621);
        check("done_flag",   done, 1);
        check("done_misses", misses, 2*PEN + 2);
        check("done_active", note_active, 0);

        frame();
        check("done_frame_misses", misses, 2*PEN + 2);
        check("done_frame_done",   done, 1);

        pulse_start();
        check("restart_score",  score, 0);
        check("restart_misses", misses, 0);
        check("restart_done",   done, 0);
        check("restart_addr",   pattern_addr, 0);
        frame();
        check("restart_spawn",  note_active, 4'b0001);
        check("restart_addr1",  pattern_addr, 1);

        @(negedge clk) rst_n = 1'b0;
        #1;
        check("midreset_addr",   pattern_addr, 0);
        check("midreset_active", note_active, 0);
        check("midreset_done",   done, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lane_note_controller.md
# lane_note_controller

Frame-synchronous gameplay controller for the lane display. Spawns notes from a pattern ROM into up to NUM_LANES lanes, scrolls them down once per video frame, and judges player button presses against a hit window. Publishes per-lane note positions for the lane renderers, plus score, miss count and per-lane hit-flash flags. Sits between the pattern ROM / button inputs and the VGA lane drawing blocks.

## Interface
- NUM_LANES, 4, number of lanes
- SPEED, 4, rows a note moves per frame
- HIT_TOP, 400, first row of hit window (inclusive)
- HIT_BOTTOM, 440, last row of hit window (inclusive)
- MISS_ROW, 460, note at row > MISS_ROW is a miss
- STEP_FRAMES, 8, frames per pattern step
- PATTERN_LEN, 64, pattern steps per song
- ADDR_W, 8, pattern address width
- FLASH_FRAMES, 6, frames a lane flash stays on after a hit
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- frame_start  input  1  one-cycle pulse per video frame
- start  input  1  level; begins a song from IDLE or DONE
- btn  input  NUM_LANES  debounced, synchronised lane buttons, active high
- pattern_data  input  NUM_LANES  spawn mask for current step (async ROM, valid same cycle as pattern_addr)
- pattern_addr  output  ADDR_W  current step address
- note_active  output  NUM_LANES  lane holds a note
- note_row  output  10*NUM_LANES  packed note top rows, lane i at [10i+9:10i]
- lane_flash  output  NUM_LANES  hit flash
- score  output  16  hits, saturating at 16'hFFFF
- misses  output  16  misses, saturating at 16'hFFFF
- done  output  1  song complete

## Operation
- States: IDLE, PLAY, DRAIN, DONE. Reset → IDLE.
- IDLE/DONE + start=1: clear score, misses, notes, flashes, pattern_addr, step counter; → PLAY. done=1 only in DONE.
- Frame update (PLAY/DRAIN, cycle after frame_start): each active note row += SPEED; if new row > MISS_ROW, clear note, misses++.
- Spawn (PLAY only, same update, step counter == 0): for each lane with pattern_data[i]=1 and no active note after the move step, set note_active[i], note_row[i]=0. Spawn onto an occupied lane is discarded silently. Then pattern_addr++.
- Step counter counts frame updates 0..STEP_FRAMES-1, wraps. After spawn from address PATTERN_LEN-1 → DRAIN.
- DRAIN: no spawns; when no note active after an update → DONE.
- Hit judging (PLAY/DRAIN, every cycle): rising edge of btn[i] with note_active[i] and HIT_TOP ≤ note_row[i] ≤ HIT_BOTTOM → clear note, score++, lane_flash[i]=1 with flash counter = FLASH_FRAMES. Press outside window: ignored (see Configuration).
- lane_flash[i] counter decrements each frame update; flag clears on reaching 0. New hit reloads counter.
- Multiple lanes hit in one cycle: score increases by number of hits (saturating).
- Row arithmetic in 11 bits internally; no wrap of note_row.

## Timing
- All outputs registered; reset values: every output 0, state IDLE.
- Frame update effects visible one cycle after the frame_start cycle.
- Hit effects visible the cycle after the btn rising edge cycle (edge detect uses registered previous btn, cleared by reset).
- Press coinciding with the frame update cycle: judged on pre-update row; a hit clears the note and suppresses its move/miss.
- frame_start during IDLE/DONE: ignored.
- start while PLAY/DRAIN: ignored.
- rst_n asserted mid-song: immediate return to IDLE, all outputs 0.

## Configuration
- MISS_PENALTY_EN defined: button rising edge on lane with no note in the hit window increments misses (saturating); note state untouched.
- Undefined: such presses are ignored.

## Test plan
- Reset then start, pattern_data=4'b0001 at addr 0 only → lane 0 note_row 0, then +4 per frame; after 116 frames update note passes 460 → misses=1, note_active=0.
- Press btn[0] when note_row[0]=420 → score=1, note cleared, lane_flash[0]=1 for exactly 6 frames.
- Press and frame update same cycle with note_row=440 → hit counted, no miss, row never becomes 444.
- Spawn mask 4'b0001 on lane 0 occupied at row 20 (STEP_FRAMES=1) → no new note, lane 0 row continues 24.
- Full PATTERN_LEN=64 song → pattern_addr stops at 64, DRAIN until empty, done=1; start restarts with score=0.
- With MISS_PENALTY_EN, press btn[2] with no note → misses=1; without macro → misses=0.
